tdm_voice_scheduler: RTL and testbench
======================================

TDM_VOICE_SCHEDULER -- requirements
Module: tdm_voice_scheduler

Interface
REQ-001 Parameter VOICES, default 4: voice slots per frame.
REQ-002 Parameter VOICES_BITS, default 2: channel index width.
REQ-003 Parameter PHASE_W, default 24: phase accumulator and tuning word width.
REQ-004 Parameter ADDR_W, default 8: wavetable address width; address = phase[PHASE_W-1 -: ADDR_W].
REQ-005 sys_clk  in  1  system clock (48 MHz); all logic on rising edge.
REQ-006 sys_rst_n  in  1  reset; one clock, asynchronous, active-low.
REQ-007 sample_tick  in  1  one-cycle frame start strobe at the audio sample rate.
REQ-008 cfg_we  in  1  configuration write strobe.
REQ-009 cfg_ch  in  VOICES_BITS  target channel.
REQ-010 cfg_addr  in  2  register select: 0 = tuning word, 1 = wave select, 2 = enable, 3 = clear overrun.
REQ-011 cfg_data  in  PHASE_W  write data; wave uses [1:0], enable uses [0].
REQ-012 nco_addr_out  out  ADDR_W  wavetable address for the current slot.
REQ-013 selected_wave  out  2  wave select for the current slot (0 sin, 1 tri, 2 sqr, 3 saw).
REQ-014 is_chan_en  out  1  enable flag for the current slot.
REQ-015 channel_num  out  VOICES_BITS  channel index for the current slot.
REQ-016 slot_valid  out  1  high while slot outputs are valid.
REQ-017 frame_busy  out  1  high while the FSM is not IDLE.
REQ-018 frame_done  out  1  one-cycle pulse at the end of a frame.
REQ-019 overrun  out  1  sticky flag: a tick arrived while busy.

Function
REQ-020 FSM states are IDLE, ISSUE and DRAIN; a 2-bit slot counter advances only in ISSUE.
REQ-021 IDLE: on sample_tick, go to ISSUE with slot = 0; otherwise stay in IDLE.
REQ-022 ISSUE: each cycle registers slot k outputs, increments slot, and moves to DRAIN after slot VOICES-1.
REQ-023 DRAIN lasts exactly one cycle, covering the BRAM negedge read and tag delay; it then returns to IDLE with a frame_done pulse.
REQ-024 Timing for a tick sampled at posedge N:
- slot k outputs are valid in the cycle after posedge N+1+k;
- slot_valid is high for exactly VOICES cycles;
- frame_done is high in the cycle after posedge N+VOICES+1;
- frame_busy is high from posedge N to posedge N+VOICES+1.
REQ-025 Slot k outputs:
- nco_addr_out = top ADDR_W bits of phase[k] before this frame's increment;
- selected_wave = wave[k];
- is_chan_en = en[k];
- channel_num = k.
REQ-026 Phase update during slot k:
- if en[k] is set, phase[k] <= phase[k] + tuning[k] modulo 2^PHASE_W (wrap silently, no flag);
- if en[k] is clear, phase[k] <= 0.
REQ-027 Disabled channels are still issued, with is_chan_en = 0 and address = 0.
REQ-028 With slot_valid low, nco_addr_out, selected_wave, is_chan_en and channel_num hold their last values.
REQ-029 Config writes take effect at the next posedge in any state.
REQ-030 If a write targets the channel being issued in the same cycle, that slot uses the old value; the new value applies from the next frame.
REQ-031 A sample_tick in ISSUE or DRAIN is ignored and sets overrun.
REQ-032 overrun is cleared only by reset or a write with cfg_addr = 3; if a tick collides with the clear in the same cycle, set wins.
REQ-033 A sample_tick coinciding with the frame_done cycle (state IDLE) starts a new frame normally.

Reset
REQ-034 Asserting sys_rst_n low immediately forces:
- FSM to IDLE, slot = 0;
- all phase, tuning, wave and en to 0;
- all outputs to 0.
REQ-035 Reset mid-frame aborts the frame with no frame_done; after release, the first tick starts a fresh frame at slot 0.

Verification
REQ-036 Ch0: en = 1, tuning = 0x010000. Three ticks spaced 10 cycles -> ch0 nco_addr_out = 0x00, 0x01, 0x02; slots 1-3 show is_chan_en = 0, addr 0x00.
REQ-037 Ch2: en = 1, tuning = 0x800000, wave = 3. Ticks -> ch2 addr alternates 0x00, 0x80, 0x00; selected_wave = 3 on slot 2 only.
REQ-038 Tick at posedge N -> slot_valid high for cycles N+1..N+4; channel_num 0,1,2,3; frame_done at N+5; frame_busy N..N+5.
REQ-039 Second tick at N+2 -> ignored, overrun = 1 and held. cfg_addr = 3 write -> overrun = 0. Tick in the frame_done cycle -> new frame, overrun stays 0.
REQ-040 Ch1 tuning rewritten from 0x010000 to 0x040000 during slot 1 -> this frame increments by 0x010000, next frame by 0x040000.
REQ-041 sys_rst_n pulsed low during slot 2 -> outputs 0 immediately, no frame_done; next tick -> slot 0, addresses 0x00.

Source files
------------

// File: rtl/tdm_voice_scheduler.sv
// TDM voice scheduler: on each sample tick, issues one wavetable slot per
// voice (address, wave select, enable, channel index), advances each voice's
// phase accumulator, then spends one drain cycle before signalling frame_done.
module tdm_voice_scheduler #(
  parameter int VOICES      = 4,
  parameter int VOICES_BITS = 2,
  parameter int PHASE_W     = 24,
  parameter int ADDR_W      = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   sample_tick,
  input  logic                   cfg_we,
  input  logic [VOICES_BITS-1:0] cfg_ch,
  input  logic [1:0]             cfg_addr,
  input  logic [PHASE_W-1:0]     cfg_data,
  output logic [ADDR_W-1:0]      nco_addr_out,
  output logic [1:0]             selected_wave,
  output logic                   is_chan_en,
  output logic [VOICES_BITS-1:0] channel_num,
  output logic                   slot_valid,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic                   overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] REG_TUNE = 2'd0;
  localparam logic [1:0] REG_WAVE = 2'd1;
  localparam logic [1:0] REG_EN   = 2'd2;
  localparam logic [1:0] REG_CLR  = 2'd3;

  state_t                 state_q, state_d;
  logic [VOICES_BITS-1:0] slot_q, slot_d;

  logic [PHASE_W-1:0] phase_q  [VOICES];
  logic [PHASE_W-1:0] phase_d  [VOICES];
  logic [PHASE_W-1:0] tuning_q [VOICES];
  logic [PHASE_W-1:0] tuning_d [VOICES];
  logic [1:0]         wave_q   [VOICES];
  logic [1:0]         wave_d   [VOICES];
  logic               en_q     [VOICES];
  logic               en_d     [VOICES];

  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [1:0]             sel_wave_q, sel_wave_d;
  logic                   chan_en_q, chan_en_d;
  logic [VOICES_BITS-1:0] chan_q, chan_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;

  logic clr_overrun;

  // Next-state: config writes, FSM sequencing, slot issue and phase update.
  // Slot issue reads the _q copies, so a same-cycle write to the slot being
  // issued only takes effect in the following frame.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    phase_d    = phase_q;
    tuning_d   = tuning_q;
    wave_d     = wave_q;
    en_d       = en_q;
    addr_d     = addr_q;
    sel_wave_d = sel_wave_q;
    chan_en_d  = chan_en_q;
    chan_d     = chan_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    clr_overrun = 1'b0;

    if (cfg_we) begin
      case (cfg_addr)
        REG_TUNE: tuning_d[cfg_ch] = cfg_data;
        REG_WAVE: wave_d[cfg_ch]   = cfg_data[1:0];
        REG_EN:   en_d[cfg_ch]     = cfg_data[0];
        default:  clr_overrun      = 1'b1;
      endcase
    end

    // A tick that lands while busy always sets the flag, even against a clear.
    overrun_d = (overrun_q & ~clr_overrun) | (sample_tick & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = ISSUE;
          slot_d  = '0;
        end
      end
      ISSUE: begin
        valid_d    = 1'b1;
        chan_d     = slot_q;
        sel_wave_d = wave_q[slot_q];
        chan_en_d  = en_q[slot_q];
        if (en_q[slot_q]) begin
          addr_d          = phase_q[slot_q][PHASE_W-1 -: ADDR_W];
          phase_d[slot_q] = phase_q[slot_q] + tuning_q[slot_q];
        end else begin
          addr_d          = '0;
          phase_d[slot_q] = '0;
        end
        if (slot_q == VOICES_BITS'(VOICES - 1)) begin
          state_d = DRAIN;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + VOICES_BITS'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        slot_d  = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset clears all voice state and outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      phase_q    <= '{default: '0};
      tuning_q   <= '{default: '0};
      wave_q     <= '{default: '0};
      en_q       <= '{default: 1'b0};
      addr_q     <= '0;
      sel_wave_q <= '0;
      chan_en_q  <= 1'b0;
      chan_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      phase_q    <= phase_d;
      tuning_q   <= tuning_d;
      wave_q     <= wave_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      sel_wave_q <= sel_wave_d;
      chan_en_q  <= chan_en_d;
      chan_q     <= chan_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign nco_addr_out  = addr_q;
  assign selected_wave = sel_wave_q;
  assign is_chan_en    = chan_en_q;
  assign channel_num   = chan_q;
  assign slot_valid    = valid_q;
  assign frame_busy    = busy_q;
  assign frame_done    = done_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_tdm_voice_scheduler.sv
// Directed testbench for tdm_voice_scheduler (default parameters).
// Inputs change just after a falling edge; outputs are sampled at falling edges.
module tb_tdm_voice_scheduler;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        sample_tick;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_addr;
  logic [23:0] cfg_data;
  logic [7:0]  nco_addr_out;
  logic [1:0]  selected_wave;
  logic        is_chan_en;
  logic [1:0]  channel_num;
  logic        slot_valid;
  logic        frame_busy;
  logic        frame_done;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_addr  [4];
  logic [1:0] got_wave  [4];
  logic       got_en    [4];
  logic [1:0] got_ch    [4];
  logic       got_valid [4];
  logic       got_done;

  tdm_voice_scheduler #(
    .VOICES      (4),
    .VOICES_BITS (2),
    .PHASE_W     (24),
    .ADDR_W      (8)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .sample_tick   (sample_tick),
    .cfg_we        (cfg_we),
    .cfg_ch        (cfg_ch),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .nco_addr_out  (nco_addr_out),
    .selected_wave (selected_wave),
    .is_chan_en    (is_chan_en),
    .channel_num   (channel_num),
    .slot_valid    (slot_valid),
    .frame_busy    (frame_busy),
    .frame_done    (frame_done),
    .overrun       (overrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] a, input logic [23:0] d);
    cfg_we = 1'b1; cfg_ch = ch; cfg_addr = a; cfg_data = d;
    @(negedge sys_clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  // Tick, capture the four slots and the done cycle, optionally injecting a
  // config write into the cycle that registers slot wr_slot.
  task automatic run_frame(input int wr_slot, input logic [1:0] wr_ch,
                           input logic [1:0] wr_a, input logic [23:0] wr_d);
    sample_tick = 1'b1;
    @(negedge sys_clk);
    sample_tick = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == wr_slot) begin
        cfg_we = 1'b1; cfg_ch = wr_ch; cfg_addr = wr_a; cfg_data = wr_d;
      end
      @(negedge sys_clk);
      cfg_we = 1'b0;
      got_addr[k]  = nco_addr_out;
      got_wave[k]  = selected_wave;
      got_en[k]    = is_chan_en;
      got_ch[k]    = channel_num;
      got_valid[k] = slot_valid;
    end
    @(negedge sys_clk);
    got_done = frame_done;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    checks++;
    if ({nco_addr_out, selected_wave, is_chan_en, channel_num, slot_valid,
         frame_busy, frame_done, overrun} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs: got addr=%h wave=%0d en=%b ch=%0d valid=%b busy=%b done=%b ovr=%b, expected all 0",
               nco_addr_out, selected_wave, is_chan_en, channel_num, slot_valid, frame_busy, frame_done, overrun);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_frame_timing();
    sample_tick = 1'b1;
    @(negedge sys_clk);
    sample_tick = 1'b0;
    checks++;
    if (frame_busy !== 1'b1 || slot_valid !== 1'b0) begin
      failures++;
      $display("FAIL timing_tick_cycle: busy=%b valid=%b, expected busy=1 valid=0", frame_busy, slot_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      checks++;
      if (slot_valid !== 1'b1 || channel_num !== k[1:0] || frame_busy !== 1'b1 || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL timing_slot%0d: valid=%b ch=%0d busy=%b done=%b, expected 1 %0d 1 0",
                 k, slot_valid, channel_num, frame_busy, frame_done, k);
      end
    end
    @(negedge sys_clk);
    checks++;
    if (frame_done !== 1'b1 || slot_valid !== 1'b0 || frame_busy !== 1'b0) begin
      failures++;
      $display("FAIL timing_done_cycle: done=%b valid=%b busy=%b, expected 1 0 0", frame_done, slot_valid, frame_busy);
    end
    @(negedge sys_clk);
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL timing_done_pulse: done=%b, expected 0", frame_done);
    end
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_ch0_nco();
    cfg_write(2'd0, 2'd0, 24'h010000);
    cfg_write(2'd0, 2'd2, 24'h000001);
    for (int f = 0; f < 3; f++) begin
      run_frame(-1, 2'd0, 2'd0, 24'h0);
      checks++;
      if (got_addr[0] !== f[7:0] || got_en[0] !== 1'b1) begin
        failures++;
        $display("FAIL ch0_frame%0d: addr=%h en=%b, expected addr=%h en=1", f, got_addr[0], got_en[0], f[7:0]);
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (got_en[k] !== 1'b0 || got_addr[k] !== 8'h00) begin
          failures++;
          $display("FAIL ch0_disabled_slot%0d: en=%b addr=%h, expected 0 00", k, got_en[k], got_addr[k]);
        end
      end
      checks++;
      if (got_done !== 1'b1) begin
        failures++;
        $display("FAIL ch0_done%0d: done=%b, expected 1", f, got_done);
      end
    end
  endtask

  task automatic test_ch2_wave();
    logic [7:0] exp_addr [3];
    exp_addr[0] = 8'h00; exp_addr[1] = 8'h80; exp_addr[2] = 8'h00;
    cfg_write(2'd2, 2'd0, 24'h800000);
    cfg_write(2'd2, 2'd1, 24'h000003);
    cfg_write(2'd2, 2'd2, 24'h000001);
    for (int f = 0; f < 3; f++) begin
      run_frame(-1, 2'd0, 2'd0, 24'h0);
      checks++;
      if (got_addr[2] !== exp_addr[f] || got_wave[2] !== 2'd3 || got_ch[2] !== 2'd2) begin
        failures++;
        $display("FAIL ch2_frame%0d: addr=%h wave=%0d ch=%0d, expected %h 3 2",
                 f, got_addr[2], got_wave[2], got_ch[2], exp_addr[f]);
      end
      checks++;
      if (got_wave[0] !== 2'd0 || got_wave[1] !== 2'd0 || got_wave[3] !== 2'd0) begin
        failures++;
        $display("FAIL ch2_other_waves%0d: waves=%0d,%0d,%0d expected 0,0,0", f, got_wave[0], got_wave[1], got_wave[3]);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    sample_tick = 1'b1; @(negedge sys_clk); sample_tick = 1'b0;
    @(negedge sys_clk);
    sample_tick = 1'b1; @(negedge sys_clk); sample_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: overrun=%b, expected 1", overrun);
    end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (frame_done !== 1'b1 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_hold: done=%b overrun=%b, expected 1 1", frame_done, overrun);
    end
    @(negedge sys_clk);
    checks++;
    if (frame_busy !== 1'b0) begin
      failures++;
      $display("FAIL overrun_no_restart: busy=%b, expected 0", frame_busy);
    end
    cfg_write(2'd1, 2'd3, 24'h0);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear: overrun=%b, expected 0", overrun);
    end
    // tick during ISSUE colliding with a clear
    sample_tick = 1'b1; @(negedge sys_clk); sample_tick = 1'b0;
    @(negedge sys_clk);
    sample_tick = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 2'd3; cfg_data = 24'h0;
    @(negedge sys_clk);
    sample_tick = 1'b0; cfg_we = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set_wins: overrun=%b, expected 1", overrun);
    end
    repeat (3) @(negedge sys_clk);
    cfg_write(2'd0, 2'd3, 24'h0);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear2: overrun=%b, expected 0", overrun);
    end
    // tick in the frame_done cycle starts a new frame
    sample_tick = 1'b1; @(negedge sys_clk); sample_tick = 1'b0;
    repeat (4) @(negedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL overrun_b2b_done: done=%b, expected 1", frame_done);
    end
    sample_tick = 1'b1; @(negedge sys_clk); sample_tick = 1'b0;
    checks++;
    if (frame_busy !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_start: busy=%b overrun=%b, expected 1 0", frame_busy, overrun);
    end
    @(negedge sys_clk);
    checks++;
    if (slot_valid !== 1'b1 || channel_num !== 2'd0) begin
      failures++;
      $display("FAIL back_to_back_slot0: valid=%b ch=%0d, expected 1 0", slot_valid, channel_num);
    end
    repeat (3) @(negedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (frame_done !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_done: done=%b overrun=%b, expected 1 0", frame_done, overrun);
    end
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_retune();
    logic [7:0] exp_addr [4];
    exp_addr[0] = 8'h00; exp_addr[1] = 8'h01; exp_addr[2] = 8'h02; exp_addr[3] = 8'h06;
    do_reset();
    cfg_write(2'd1, 2'd0, 24'h010000);
    cfg_write(2'd1, 2'd2, 24'h000001);
    for (int f = 0; f < 4; f++) begin
      if (f == 1) run_frame(1, 2'd1, 2'd0, 24'h040000);
      else        run_frame(-1, 2'd0, 2'd0, 24'h0);
      checks++;
      if (got_addr[1] !== exp_addr[f]) begin
        failures++;
        $display("FAIL retune_frame%0d: ch1 addr=%h, expected %h", f, got_addr[1], exp_addr[f]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int done_seen;
    do_reset();
    cfg_write(2'd0, 2'd0, 24'h010000);
    cfg_write(2'd0, 2'd2, 24'h000001);
    run_frame(-1, 2'd0, 2'd0, 24'h0);
    sample_tick = 1'b1; @(negedge sys_clk); sample_tick = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (slot_valid !== 1'b1 || channel_num !== 2'd2) begin
      failures++;
      $display("FAIL midreset_pre: valid=%b ch=%0d, expected 1 2", slot_valid, channel_num);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({nco_addr_out, selected_wave, is_chan_en, channel_num, slot_valid,
         frame_busy, frame_done, overrun} !== 17'd0) begin
      failures++;
      $display("FAIL midreset_outputs: addr=%h wave=%0d en=%b ch=%0d valid=%b busy=%b done=%b, expected all 0",
               nco_addr_out, selected_wave, is_chan_en, channel_num, slot_valid, frame_busy, frame_done);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (frame_done !== 1'b0 || frame_busy !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL midreset_no_done: %0d cycles with done/busy set, expected 0", done_seen);
    end
    run_frame(-1, 2'd0, 2'd0, 24'h0);
    checks++;
    if (got_ch[0] !== 2'd0 || got_valid[0] !== 1'b1 || got_done !== 1'b1) begin
      failures++;
      $display("FAIL midreset_fresh_frame: ch=%0d valid=%b done=%b, expected 0 1 1", got_ch[0], got_valid[0], got_done);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_addr[k] !== 8'h00 || got_en[k] !== 1'b0) begin
        failures++;
        $display("FAIL midreset_slot%0d: addr=%h en=%b, expected 00 0", k, got_addr[k], got_en[k]);
      end
    end
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    sample_tick = 1'b0;
    cfg_we      = 1'b0;
    cfg_ch      = '0;
    cfg_addr    = '0;
    cfg_data    = '0;
    test_reset();
    test_frame_timing();
    test_ch0_nco();
    test_ch2_wave();
    test_overrun();
    test_retune();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
